mole_game_ctrl: RTL and testbench

//  Top-level game sequencer for the mole game; sits directly upstream of the text LCD driver.

---
 rtl/mole_game_pkg.sv | 25 ++
 rtl/sec_tick_gen.sv | 32 +++
 rtl/mole_game_ctrl.sv | 148 ++++++++++++++
 tb/tb_mole_game_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_game_pkg.sv
// Shared definitions for the mole game sequencer and the LCD driver that
// decodes its state code.
package mole_game_pkg;

    // State codes as seen on the state[2:0] output
    localparam logic [2:0] ST_READY       = 3'd0;
    localparam logic [2:0] ST_PLAY        = 3'd1;
    localparam logic [2:0] ST_PAUSE       = 3'd2;
    localparam logic [2:0] ST_GAME_OVER   = 3'd3;
    localparam logic [2:0] ST_STAGE_CLEAR = 3'd4;
    localparam logic [2:0] ST_GAME_CLEAR  = 3'd5;

    // Width of the stage number output
    localparam int STAGE_W = 2;

    typedef enum logic [2:0] {
        S_READY       = ST_READY,
        S_PLAY        = ST_PLAY,
        S_PAUSE       = ST_PAUSE,
        S_GAME_OVER   = ST_GAME_OVER,
        S_STAGE_CLEAR = ST_STAGE_CLEAR,
        S_GAME_CLEAR  = ST_GAME_CLEAR
    } game_state_t;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler. Counts while run is high, freezes while run is
// low, and restarts from zero when clr is high. tick marks the wrap cycle.
module sec_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk_1mhz,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // The wrap cycle is visible combinationally so the sequencer acts on the same edge
    assign tick = run && (cnt == LAST);

    // Prescaler: clear has priority, otherwise count 0..TICK_DIV-1 while running
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mole_game_ctrl.sv
// Game sequencer for the mole game: tracks stage, lives, score and the
// per-stage countdown, and drives the state code shown by the LCD driver.
module mole_game_ctrl
    import mole_game_pkg::*;
#(
    parameter int TICK_DIV       = 1_000_000,
    parameter int STAGE_TIME_S   = 30,
    parameter int HITS_PER_STAGE = 10,
    parameter int MAX_LIVES      = 3,
    parameter int NUM_STAGES     = 3,
    parameter int CLEAR_HOLD_S   = 2
) (
    input  logic               clk_1mhz,
    input  logic               rst_n,
    input  logic               btn_start,
    input  logic               hit_pulse,
    input  logic               miss_pulse,
    output logic [2:0]         state,
    output logic [STAGE_W-1:0] stage,
    output logic [7:0]         score,
    output logic [1:0]         lives,
    output logic [6:0]         time_left,
    output logic               mole_en,
    output logic               stage_start
);

    localparam logic [6:0]         TIME_INIT  = 7'(STAGE_TIME_S);
    localparam logic [1:0]         LIVES_INIT = 2'(MAX_LIVES);
    localparam logic [3:0]         HITS_GOAL  = 4'(HITS_PER_STAGE);
    localparam logic [1:0]         HOLD_GOAL  = 2'(CLEAR_HOLD_S);
    localparam logic [STAGE_W-1:0] LAST_STG   = STAGE_W'(NUM_STAGES);

    game_state_t cur_state;
    logic [3:0]  hits;
    logic [1:0]  hold;
    logic        tick;
    logic        run;
    logic        go_play;
    logic        hit_done;
    logic        hold_done;
    logic        tick_clr;

    assign state = cur_state;
    assign run   = (cur_state == S_PLAY) || (cur_state == S_STAGE_CLEAR);

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_1mhz (clk_1mhz),
        .rst_n    (rst_n),
        .run      (run),
        .clr      (tick_clr),
        .tick     (tick)
    );

    // Transition events that restart the one-second prescaler
    always_comb begin
        go_play   = (cur_state == S_READY) && btn_start;
        hit_done  = (cur_state == S_PLAY) && hit_pulse && ((hits + 4'd1) == HITS_GOAL);
        hold_done = (cur_state == S_STAGE_CLEAR) && tick && ((hold + 2'd1) == HOLD_GOAL);
        tick_clr  = go_play || hit_done || hold_done;
    end

    // Game FSM with its stage/lives/score/time/hit/hold counters and registered outputs
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= S_READY;
            stage       <= STAGE_W'(1);
            score       <= '0;
            lives       <= LIVES_INIT;
            time_left   <= TIME_INIT;
            hits        <= '0;
            hold        <= '0;
            mole_en     <= 1'b0;
            stage_start <= 1'b0;
        end else begin
            stage_start <= 1'b0;
            case (cur_state)
                S_READY: begin
                    if (btn_start) begin
                        cur_state   <= S_PLAY;
                        stage       <= STAGE_W'(1);
                        score       <= '0;
                        lives       <= LIVES_INIT;
                        time_left   <= TIME_INIT;
                        hits        <= '0;
                        mole_en     <= 1'b1;
                        stage_start <= 1'b1;
                    end
                end
                S_PLAY: begin
                    // Counters always update; only the state transition is prioritised
                    if (hit_pulse) begin
                        score <= (score == 8'hFF) ? score : score + 8'd1;
                        hits  <= hits + 4'd1;
                    end
                    if (miss_pulse && (lives != 2'd0)) begin
                        lives <= lives - 2'd1;
                    end
                    if (tick && (time_left != 7'd0)) begin
                        time_left <= time_left - 7'd1;
                    end
                    if (hit_done) begin
                        cur_state <= (stage == LAST_STG) ? S_GAME_CLEAR : S_STAGE_CLEAR;
                        hold      <= '0;
                        mole_en   <= 1'b0;
                    end else if ((miss_pulse && (lives <= 2'd1)) ||
                                 (tick && (time_left <= 7'd1))) begin
                        cur_state <= S_GAME_OVER;
                        mole_en   <= 1'b0;
                    end else if (btn_start) begin
                        cur_state <= S_PAUSE;
                        mole_en   <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (btn_start) begin
                        cur_state <= S_PLAY;
                        mole_en   <= 1'b1;
                    end
                end
                S_STAGE_CLEAR: begin
                    if (hold_done) begin
                        cur_state   <= S_PLAY;
                        stage       <= stage + STAGE_W'(1);
                        hits        <= '0;
                        time_left   <= TIME_INIT;
                        mole_en     <= 1'b1;
                        stage_start <= 1'b1;
                    end else if (tick) begin
                        hold <= hold + 2'd1;
                    end
                end
                S_GAME_OVER, S_GAME_CLEAR: begin
                    if (btn_start) begin
                        cur_state <= S_READY;
                        stage     <= STAGE_W'(1);
                    end
                end
                default: begin
                    cur_state <= S_READY;
                    mole_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed game scenarios with literal expectations,
// then randomized pulses, all compared every cycle against a behavioural model.
module tb_mole_game_ctrl;

    localparam int P_DIV   = 10;
    localparam int P_TIME  = 5;
    localparam int P_HITS  = 2;
    localparam int P_LIVES = 2;
    localparam int P_NSTG  = 2;
    localparam int P_HOLD  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       hit_pulse = 1'b0;
    logic       miss_pulse = 1'b0;
    logic [2:0] state;
    logic [1:0] stage;
    logic [7:0] score;
    logic [1:0] lives;
    logic [6:0] time_left;
    logic       mole_en;
    logic       stage_start;

    int total = 0;
    int bad   = 0;

    // Model of the game: 0 READY 1 PLAY 2 PAUSE 3 OVER 4 STAGE_CLEAR 5 GAME_CLEAR
    int m_state = 0, m_stage = 1, m_score = 0, m_lives = P_LIVES, m_time = P_TIME;
    int m_hits = 0, m_pre = 0, m_hold = 0, m_ss = 0;

    always #5 clk = ~clk;

    mole_game_ctrl #(
        .TICK_DIV       (P_DIV),
        .STAGE_TIME_S   (P_TIME),
        .HITS_PER_STAGE (P_HITS),
        .MAX_LIVES      (P_LIVES),
        .NUM_STAGES     (P_NSTG),
        .CLEAR_HOLD_S   (P_HOLD)
    ) dut (
        .clk_1mhz    (clk),
        .rst_n       (rst_n),
        .btn_start   (btn_start),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .state       (state),
        .stage       (stage),
        .score       (score),
        .lives       (lives),
        .time_left   (time_left),
        .mole_en     (mole_en),
        .stage_start (stage_start)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_stage = 1; m_score = 0; m_lives = P_LIVES; m_time = P_TIME;
        m_hits = 0; m_pre = 0; m_hold = 0; m_ss = 0;
    endtask

    task automatic model_step(input bit s, input bit h, input bit m);
        bit running, tick, cleared, dead;
        running = (m_state == 1) || (m_state == 4);
        tick    = running && (m_pre == P_DIV - 1);
        if (running) m_pre = (m_pre + 1) % P_DIV;
        m_ss = 0; cleared = 0; dead = 0;
        case (m_state)
            0: if (s) begin
                m_stage = 1; m_score = 0; m_lives = P_LIVES; m_time = P_TIME;
                m_hits = 0; m_pre = 0; m_state = 1; m_ss = 1;
            end
            1: begin
                if (h) begin
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_hits++;
                    cleared = (m_hits == P_HITS);
                end
                if (m) begin
                    dead = (m_lives <= 1);
                    if (m_lives > 0) m_lives--;
                end
                if (tick) begin
                    if (m_time <= 1) dead = 1;
                    if (m_time > 0) m_time--;
                end
                if (cleared) begin
                    m_state = (m_stage == P_NSTG) ? 5 : 4;
                    m_pre = 0; m_hold = 0;
                end else if (dead) m_state = 3;
                else if (s) m_state = 2;
            end
            2: if (s) m_state = 1;
            4: if (tick) begin
                m_hold++;
                if (m_hold == P_HOLD) begin
                    m_stage++; m_hits = 0; m_time = P_TIME; m_pre = 0;
                    m_state = 1; m_ss = 1;
                end
            end
            3, 5: if (s) begin m_state = 0; m_stage = 1; end
            default: m_state = 0;
        endcase
    endtask

    // Model advances on each clock edge, resets asynchronously like the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(btn_start, hit_pulse, miss_pulse);
    end

    // Compare every output against the model on the inactive edge
    always @(negedge clk) begin
        check("state",       int'(state),       m_state);
        check("stage",       int'(stage),       m_stage);
        check("score",       int'(score),       m_score);
        check("lives",       int'(lives),       m_lives);
        check("time_left",   int'(time_left),   m_time);
        check("mole_en",     int'(mole_en),     (m_state == 1) ? 1 : 0);
        check("stage_start", int'(stage_start), m_ss);
    end

    // One clock with the given pulses, returning 1 time unit after the edge
    task automatic cyc(input bit s, input bit h, input bit m);
        btn_start = s; hit_pulse = h; miss_pulse = m;
        @(posedge clk);
        #1;
        btn_start = 0; hit_pulse = 0; miss_pulse = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_lives", int'(lives), 2);
        check("rst_time",  int'(time_left), 5);
        rst_n = 1'b1;
        idle(2);

        // Stage 1 cleared, then hold expires into stage 2
        cyc(1, 0, 0);
        check("start_pulse", int'(stage_start), 1);
        check("start_mole",  int'(mole_en), 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        check("clr1_state", int'(state), 4);
        check("clr1_score", int'(score), 2);
        idle(9);
        check("hold_state", int'(state), 4);
        idle(1);
        check("stg2_state", int'(state), 1);
        check("stg2_stage", int'(stage), 2);
        check("stg2_time",  int'(time_left), 5);
        check("stg2_pulse", int'(stage_start), 1);

        // Stage 2 cleared -> game clear -> back to READY
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        check("gclr_state", int'(state), 5);
        check("gclr_score", int'(score), 4);
        check("gclr_mole",  int'(mole_en), 0);
        cyc(1, 0, 0);
        check("rdy_state", int'(state), 0);
        check("rdy_stage", int'(stage), 1);

        // Two misses end the game; later hits are ignored
        cyc(1, 0, 0);
        check("new_score", int'(score), 0);
        cyc(0, 0, 1);
        check("miss1_lives", int'(lives), 1);
        check("miss1_state", int'(state), 1);
        cyc(0, 0, 1);
        check("miss2_lives", int'(lives), 0);
        check("miss2_state", int'(state), 3);
        cyc(0, 1, 0);
        check("over_score", int'(score), 0);

        // Timeout after five ticks with no input
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        idle(49);
        check("to_time1",  int'(time_left), 1);
        check("to_state1", int'(state), 1);
        idle(1);
        check("to_state", int'(state), 3);
        check("to_time0", int'(time_left), 0);

        // Pause mid-second freezes the prescaler
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        idle(25);
        check("pre_pause_time", int'(time_left), 3);
        cyc(1, 0, 0);
        check("pause_state", int'(state), 2);
        idle(100);
        check("pause_time", int'(time_left), 3);
        cyc(1, 0, 0);
        check("resume_state", int'(state), 1);
        check("resume_pulse", int'(stage_start), 0);
        idle(3);
        check("resume_time3", int'(time_left), 3);
        idle(1);
        check("resume_time2", int'(time_left), 2);

        // Clearing hit beats the last-life miss in the same cycle
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 1);
        check("tie_state", int'(state), 4);
        check("tie_lives", int'(lives), 0);
        idle(10);
        check("tie_stage", int'(stage), 2);
        idle(3);

        // Asynchronous reset mid-PLAY
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_stage", int'(stage), 1);
        check("arst_score", int'(score), 0);
        check("arst_lives", int'(lives), 2);
        check("arst_time",  int'(time_left), 5);
        check("arst_mole",  int'(mole_en), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Randomized play
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 999) < 2) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 19) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 11) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
